// File: rtl/pdp8_arith_pkg.sv
// Shared types and constants for the PDP-8 EAE arithmetic units.
// Used by the sequential divider and its step datapath.
package pdp8_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        WAIT_LOW
    } div_state_t;

    localparam int WORD_W    = 12;
    localparam int DIV_STEPS = WORD_W;

endpackage

// File: rtl/seq_divide_div_step.sv
// One restoring-division step: shift {R,Q} left, then subtract the
// divisor from R when it fits and record the quotient bit.
module div_step
    import pdp8_arith_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] dvsr_ext;
    logic           fits;

    // R < divisor before the shift, so the shifted value needs one extra bit
    assign r_sh     = {r_in, q_in[WIDTH-1]};
    assign dvsr_ext = {1'b0, divisor};
    assign fits     = (r_sh >= dvsr_ext);

    always_comb begin
        r_out = r_sh[WIDTH-1:0];
        q_out = {q_in[WIDTH-2:0], 1'b0};
        if (fits) begin
            r_out = WIDTH'(r_sh - dvsr_ext);
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divide.sv
// Sequential restoring divider for the EAE: {AC,MQ} / divisor, one
// quotient bit per clock, with divide-overflow detection at launch.
module seq_divide
    import pdp8_arith_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               start,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               overflow,
    output logic               finished
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    assign div_hi = dividend[2*WIDTH-1:WIDTH];
    assign div_lo = dividend[WIDTH-1:0];

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r_in   (r_q),
        .q_in   (q_q),
        .divisor(dvsr_q),
        .r_out  (step_r),
        .q_out  (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvsr_d = divisor;
                    r_d    = div_hi;
                    q_d    = div_lo;
                    cnt_d  = '0;
                    // A high half >= divisor cannot yield a WIDTH-bit quotient
                    if (div_hi >= divisor) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        ovf_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign overflow  = ovf_q;
    assign finished  = (state_q == DONE);

endmodule

// File: tb/tb_seq_divide.sv
// Directed and randomized checks for the sequential restoring divider.
module tb_seq_divide;
    import pdp8_arith_pkg::*;

    logic        clock;
    logic        reset;
    logic [23:0] dividend;
    logic [11:0] divisor;
    logic        start;
    logic [11:0] quotient;
    logic [11:0] remainder;
    logic        overflow;
    logic        finished;

    int total;
    int bad;

    seq_divide #(.WIDTH(12)) dut (
        .clock    (clock),
        .reset    (reset),
        .dividend (dividend),
        .divisor  (divisor),
        .start    (start),
        .quotient (quotient),
        .remainder(remainder),
        .overflow (overflow),
        .finished (finished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Launch with a one-cycle start pulse; edges counts E0 inclusive up to DONE.
    task automatic run_div(input logic [23:0] dd, input logic [11:0] ds,
                           output int edges);
        @(negedge clock);
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        edges    = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (finished) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({quotient, remainder, overflow, finished} !== 26'd0) begin
            $display("FAIL reset_outputs: got q=%h r=%h ov=%b fin=%b want 0",
                     quotient, remainder, overflow, finished);
            bad++;
        end
        total++;
        if (dut.state_q !== IDLE) begin
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
            bad++;
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int e;
        run_div(24'd100, 12'd7, e);
        total++;
        if (e !== 13) begin
            $display("FAIL basic_latency: got %0d want 13", e);
            bad++;
        end
        total++;
        if (quotient !== 12'd14 || remainder !== 12'd2 || overflow !== 1'b0) begin
            $display("FAIL basic_result: got q=%0d r=%0d ov=%b want 14 2 0",
                     quotient, remainder, overflow);
            bad++;
        end
        @(negedge clock);
        total++;
        if (finished !== 1'b0) begin
            $display("FAIL basic_pulse: finished=%b want 0", finished);
            bad++;
        end
    endtask

    task automatic test_max;
        int e;
        run_div(24'hFFEFFF, 12'hFFF, e);
        total++;
        if (e !== 13 || quotient !== 12'hFFF || remainder !== 12'hFFE ||
            overflow !== 1'b0) begin
            $display("FAIL max_result: got e=%0d q=%h r=%h ov=%b want 13 fff ffe 0",
                     e, quotient, remainder, overflow);
            bad++;
        end
    endtask

    task automatic test_overflow;
        int e;
        run_div(24'h123456, 12'h000, e);
        total++;
        if (e !== 1) begin
            $display("FAIL ovf_zero_latency: got %0d want 1", e);
            bad++;
        end
        total++;
        if (overflow !== 1'b1 || quotient !== 12'h456 || remainder !== 12'h123) begin
            $display("FAIL ovf_zero_result: got q=%h r=%h ov=%b want 456 123 1",
                     quotient, remainder, overflow);
            bad++;
        end
        run_div(24'h005000, 12'h005, e);
        total++;
        if (e !== 1 || overflow !== 1'b1 || quotient !== 12'h000 ||
            remainder !== 12'h005) begin
            $display("FAIL ovf_equal: got e=%0d q=%h r=%h ov=%b want 1 000 005 1",
                     e, quotient, remainder, overflow);
            bad++;
        end
        run_div(24'd100, 12'd7, e);
        total++;
        if (overflow !== 1'b0 || quotient !== 12'd14) begin
            $display("FAIL ovf_clear: got ov=%b q=%0d want 0 14", overflow, quotient);
            bad++;
        end
    endtask

    task automatic test_start_held;
        int pulses;
        int unstable;
        @(negedge clock);
        dividend = 24'd1000;
        divisor  = 12'd33;
        start    = 1'b1;
        pulses   = 0;
        unstable = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (finished) pulses++;
            if (k > 14 && (quotient !== 12'd30 || remainder !== 12'd10))
                unstable++;
        end
        total++;
        if (pulses !== 1) begin
            $display("FAIL held_pulses: got %0d want 1", pulses);
            bad++;
        end
        total++;
        if (dut.state_q !== WAIT_LOW) begin
            $display("FAIL held_state: got %0d want WAIT_LOW", dut.state_q);
            bad++;
        end
        total++;
        if (unstable !== 0) begin
            $display("FAIL held_stable: got %0d unstable cycles want 0", unstable);
            bad++;
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (dut.state_q !== IDLE || finished !== 1'b0 || quotient !== 12'd30) begin
            $display("FAIL held_release: got st=%0d fin=%b q=%0d want IDLE 0 30",
                     dut.state_q, finished, quotient);
            bad++;
        end
    endtask

    task automatic test_reset_mid_run;
        int pulses;
        int e;
        @(negedge clock);
        dividend = 24'd100;
        divisor  = 12'd7;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (dut.state_q !== IDLE || {quotient, remainder, overflow, finished} !== 26'd0) begin
            $display("FAIL midreset_clear: got st=%0d q=%h r=%h ov=%b fin=%b want IDLE 0",
                     dut.state_q, quotient, remainder, overflow, finished);
            bad++;
        end
        reset  = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clock);
            if (finished) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            $display("FAIL midreset_nopulse: got %0d pulses want 0", pulses);
            bad++;
        end
        run_div(24'd100, 12'd7, e);
        total++;
        if (e !== 13 || quotient !== 12'd14 || remainder !== 12'd2) begin
            $display("FAIL midreset_relaunch: got e=%0d q=%0d r=%0d want 13 14 2",
                     e, quotient, remainder);
            bad++;
        end
    endtask

    task automatic test_operand_change;
        int e;
        int pulses;
        @(negedge clock);
        dividend = 24'd200;
        divisor  = 12'd9;
        start    = 1'b1;
        e        = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            start    = (k < 8) ? k[0] : 1'b0;
            dividend = 24'(k * 777);
            divisor  = 12'(k + 1);
            if (finished) begin
                e = k;
                break;
            end
        end
        total++;
        if (e !== 13 || quotient !== 12'd22 || remainder !== 12'd2) begin
            $display("FAIL opchange_result: got e=%0d q=%0d r=%0d want 13 22 2",
                     e, quotient, remainder);
            bad++;
        end
        pulses = 0;
        repeat (5) begin
            @(negedge clock);
            if (finished) pulses++;
        end
        total++;
        if (pulses !== 0 || quotient !== 12'd22) begin
            $display("FAIL opchange_norelaunch: got pulses=%0d q=%0d want 0 22",
                     pulses, quotient);
            bad++;
        end
    endtask

    task automatic test_random;
        int e;
        logic [11:0] ds;
        logic [11:0] hi;
        logic [11:0] lo;
        logic [23:0] dd;
        logic [23:0] exp_q;
        logic [23:0] exp_r;
        for (int n = 0; n < 1000; n++) begin
            ds    = 12'($urandom_range(1, 4095));
            hi    = 12'($urandom % ds);
            lo    = 12'($urandom);
            dd    = {hi, lo};
            exp_q = dd / {12'd0, ds};
            exp_r = dd % {12'd0, ds};
            run_div(dd, ds, e);
            total++;
            if (e !== 13 || quotient !== exp_q[11:0] || remainder !== exp_r[11:0] ||
                overflow !== 1'b0) begin
                $display("FAIL random_%0d: %h/%h got e=%0d q=%h r=%h ov=%b want 13 %h %h 0",
                         n, dd, ds, e, quotient, remainder, overflow,
                         exp_q[11:0], exp_r[11:0]);
                bad++;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_basic;
        test_max;
        test_overflow;
        test_start_held;
        test_reset_mid_run;
        test_operand_change;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
